mvu_pe_acc: RTL and testbench
=============================

MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 SHALL have parameter SIMD, default 2: number of SIMD product lanes per beat, SIMD >= 1.
REQ-002 SHALL have parameter TDstI, default 4: width of each SIMD product lane.
REQ-003 SHALL have parameter SF, default 4: number of beats (synapse folds) per output, SF >= 1.
REQ-004 SHALL have parameter TDst, default 16: width of accumulated output.
REQ-005 SHALL have parameter PROD_SIGNED, default 1: 1 = lanes are two's complement and sign-extended; 0 = lanes are unsigned and zero-extended.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port in_v, input, 1 bit: in_prod is valid this cycle.
REQ-009 SHALL have port in_prod, input, SIMD*TDstI bits: SIMD products from the upstream SIMD units, lane i at bits [i*TDstI +: TDstI].
REQ-010 SHALL have port out_v, input-independent output, 1 bit: a one-cycle pulse marking out as valid.
REQ-011 SHALL have port out, output, TDst bits: the accumulated dot product.

Function
REQ-012 SHALL be a 2-stage pipeline: stage 1 is the adder tree, stage 2 is the fold accumulator.
REQ-013 Stage 1 SHALL extend each lane to TDst bits per PROD_SIGNED, sum all SIMD lanes, and register the sum as sum_r with sum_v <= in_v.
REQ-014 Stage 1 SHALL update sum_r only when in_v=1; sum_v SHALL follow in_v every cycle.
REQ-015 Stage 2 SHALL hold accumulator acc (TDst bits) and fold counter cnt (range 0..SF-1, width max(1,clog2(SF))).
REQ-016 When sum_v=1 and cnt<SF-1: acc <= acc+sum_r; cnt <= cnt+1; out_v <= 0.
REQ-017 When sum_v=1 and cnt==SF-1: out <= acc+sum_r; out_v <= 1; acc <= 0; cnt <= 0.
REQ-018 When sum_v=0: acc, cnt and out SHALL hold; out_v <= 0.
REQ-019 Latency SHALL be 2 cycles: the in_v beat completing a fold at edge t produces out_v=1 after edge t+2.
REQ-020 out_v SHALL be high for exactly one cycle per SF accepted beats; out SHALL hold its value until the next completion.
REQ-021 Gaps in in_v (any length) SHALL NOT affect results; the fold spans the SF accepted beats regardless of spacing.
REQ-022 Back-to-back folds with in_v continuously high SHALL sustain one output per SF cycles with no bubble; with SF=1, out_v SHALL be high every cycle after the 2-cycle fill.
REQ-023 All additions SHALL wrap modulo 2^TDst; there is no saturation and no overflow flag.
REQ-024 There SHALL be no backpressure; the downstream stage SHALL accept out whenever out_v=1.

Reset
REQ-025 On rst_n=0, asynchronously: sum_r=0, sum_v=0, acc=0, cnt=0, out=0, out_v=0.
REQ-026 Reset asserted mid-fold SHALL discard the partial sum; the first SF beats accepted after rst_n rises SHALL form a fresh fold.
REQ-027 in_v SHALL be ignored while rst_n=0. Outputs SHALL stay at reset values until the first fold completes after release.

Verification
REQ-028 Scenario 1, basic fold. Setup: SIMD=2, TDstI=4, SF=4, signed. Stimulus: lanes (1,2),(3,4),(-1,0),(2,-3), in_v held high. Response: out=8 with out_v on one cycle, 2 cycles after the 4th beat.
REQ-029 Scenario 2, gaps. Stimulus: same data as Scenario 1 with in_v low for 3 cycles between each beat. Response: out=8, exactly one out_v pulse.
REQ-030 Scenario 3, streaming. Stimulus: 3 consecutive folds, all lanes=1, in_v continuously high. Response: out=8 three times, out_v pulses spaced 4 cycles apart, acc restarts from 0 each fold.
REQ-031 Scenario 4, wrap and signedness. Setup: TDst=8, SF=1, SIMD=2. Stimulus: lanes (7,7) repeated. Response: out=14 per cycle. Repeat with PROD_SIGNED=0 and lanes 4'hF: response out=30, not -2.
REQ-032 Scenario 5, reset mid-fold. Stimulus: assert rst_n asynchronously (mid-cycle) after 2 of 4 beats, then release and feed 4 beats of all lanes=1. Response: out_v and out drop to 0 immediately on reset; the next out=8, not 12.
REQ-033 Scenario 6, SF=1 boundary. Stimulus: in_v high every cycle with random data. Response: out equals the lane sum 2 cycles later, every cycle; check against a reference model.

Source files
------------

// File: rtl/mvu_pe_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mvu_pe_acc                                                   |
// | Description : MVU processing-element accumulator. Stage 1 sums the SIMD    |
// |               product lanes, stage 2 accumulates SF beats into one output. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mvu_pe_acc #(
  parameter int SIMD        = 2,
  parameter int TDstI       = 4,
  parameter int SF          = 4,
  parameter int TDst        = 16,
  parameter int PROD_SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_v,
  input  logic [SIMD*TDstI-1:0] in_prod,
  output logic                  out_v,
  output logic [TDst-1:0]       out
);

  localparam int                c_CNT_W    = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SF - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [TDst-1:0]    w_ext [SIMD];
  logic [TDst-1:0]    w_sum;

  logic [TDst-1:0]    r_sum;
  logic               r_sum_v;
  logic [TDst-1:0]    r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic [TDst-1:0]    r_out;
  logic               r_out_v;

  // Widen each lane to the accumulator width; the size cast of a signed
  // operand sign-extends, of an unsigned one zero-extends.
  generate
    for (genvar i = 0; i < SIMD; i++) begin : g_lane
      logic [TDstI-1:0] w_lane;
      assign w_lane   = in_prod[i*TDstI +: TDstI];
      assign w_ext[i] = (PROD_SIGNED != 0) ? TDst'($signed(w_lane))
                                           : TDst'(w_lane);
    end
  endgenerate

  // Adder tree over all lanes, wrapping modulo 2^TDst.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < SIMD; i++) begin
      w_sum = w_sum + w_ext[i];
    end
  end

  // Stage 1: register the lane sum on valid beats; valid follows in_v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_sum_v <= 1'b0;
    end else begin
      r_sum_v <= in_v;
      if (in_v) begin
        r_sum <= w_sum;
      end
    end
  end

  // Stage 2: fold accumulator; emits the total on the SF-th beat and
  // restarts from zero so back-to-back folds need no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_out_v <= 1'b0;
    end else begin
      r_out_v <= 1'b0;
      if (r_sum_v) begin
        if (r_cnt == c_CNT_LAST) begin
          r_out   <= r_acc + r_sum;
          r_out_v <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc <= r_acc + r_sum;
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

  assign out   = r_out;
  assign out_v = r_out_v;

endmodule
`default_nettype wire

// File: tb/tb_mvu_pe_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mvu_pe_acc                                                |
// | Description : Bench for mvu_pe_acc: a default-parameter instance plus two  |
// |               SF=1, 8-bit instances (signed and unsigned) on shared inputs.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mvu_pe_acc;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_v;
  logic [7:0]  in_prod;

  logic        m_out_v;
  logic [15:0] m_out;
  logic        s_out_v;
  logic [7:0]  s_out;
  logic        u_out_v;
  logic [7:0]  u_out;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t q_u[$];
  int   acc [3];
  int   cnt [3];

  mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(4), .TDst(16), .PROD_SIGNED(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_prod(in_prod),
    .out_v(m_out_v), .out(m_out));

  mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(1), .TDst(8), .PROD_SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_prod(in_prod),
    .out_v(s_out_v), .out(s_out));

  mvu_pe_acc #(.SIMD(2), .TDstI(4), .SF(1), .TDst(8), .PROD_SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_prod(in_prod),
    .out_v(u_out_v), .out(u_out));

  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lane_ext(input int l, input int k);
    int v;
    v = l & 15;
    if (k != 2 && v >= 8) v = v - 16;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      acc[k] = 0;
      cnt[k] = 0;
    end
    q_m.delete();
    q_s.delete();
    q_u.delete();
  endtask

  // Reference model of one accepted beat, captured at the next rising edge.
  task automatic model_beat(input int l0, input int l1);
    exp_t e;
    int   sf;
    int   mask;
    for (int k = 0; k < 3; k++) begin
      sf   = (k == 0) ? 4 : 1;
      mask = (k == 0) ? 32'hFFFF : 32'hFF;
      acc[k] = (acc[k] + lane_ext(l0, k) + lane_ext(l1, k)) & mask;
      cnt[k] = cnt[k] + 1;
      if (cnt[k] == sf) begin
        e.val = acc[k];
        e.cyc = cyc + 2;
        if (k == 0) q_m.push_back(e);
        else if (k == 1) q_s.push_back(e);
        else q_u.push_back(e);
        acc[k] = 0;
        cnt[k] = 0;
      end
    end
  endtask

  task automatic beat(input logic v, input int l0, input int l1);
    @(posedge clk);
    #1;
    in_v    = v;
    in_prod = {l1[3:0], l0[3:0]};
    if (v && rst_n) model_beat(l0, l1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 0, 0);
  endtask

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard check of one instance on one falling edge.
  task automatic score(input int k, input logic v, input int o);
    exp_t  e;
    int    sz;
    string tag;
    tag = (k == 0) ? "main" : (k == 1) ? "s1" : "u1";
    sz  = (k == 0) ? q_m.size() : (k == 1) ? q_s.size() : q_u.size();
    if (sz > 0) begin
      e = (k == 0) ? q_m[0] : (k == 1) ? q_s[0] : q_u[0];
    end
    if (v) begin
      if (sz == 0) begin
        check_val({tag, "_unexpected_out_v"}, int'(v), 0);
      end else begin
        if (k == 0) void'(q_m.pop_front());
        else if (k == 1) void'(q_s.pop_front());
        else void'(q_u.pop_front());
        check_val({tag, "_out"}, o, e.val);
        check_val({tag, "_out_cycle"}, cyc, e.cyc);
      end
    end else if (sz > 0 && e.cyc <= cyc) begin
      if (k == 0) void'(q_m.pop_front());
      else if (k == 1) void'(q_s.pop_front());
      else void'(q_u.pop_front());
      check_val({tag, "_missing_out_v"}, int'(v), 1);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    in_v    = 1'b0;
    in_prod = '0;
    model_reset();
    fork
      begin : monitor
        while (!done) begin
          @(negedge clk);
          score(0, m_out_v, int'(m_out));
          score(1, s_out_v, int'(s_out));
          score(2, u_out_v, int'(u_out));
        end
      end
      begin : stimulus
        // Reset state, with in_v asserted to show it is ignored.
        @(posedge clk); #1; in_v = 1'b1; in_prod = 8'h11;
        @(posedge clk); #1;
        check_val("reset_out_v", int'(m_out_v), 0);
        check_val("reset_out", int'(m_out), 0);
        check_val("reset_s1_out", int'(s_out), 0);
        in_v = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Basic fold: (1,2),(3,4),(-1,0),(2,-3) -> 8.
        beat(1'b1, 1, 2); beat(1'b1, 3, 4); beat(1'b1, -1, 0); beat(1'b1, 2, -3);
        idle(4);
        check_val("hold_out", int'(m_out), 8);
        check_val("hold_out_v", int'(m_out_v), 0);

        // Same data with 3-cycle gaps between beats.
        beat(1'b1, 1, 2);  idle(3);
        beat(1'b1, 3, 4);  idle(3);
        beat(1'b1, -1, 0); idle(3);
        beat(1'b1, 2, -3); idle(4);

        // Three back-to-back folds of all-ones lanes.
        for (int i = 0; i < 12; i++) beat(1'b1, 1, 1);
        idle(4);
        check_val("stream_out", int'(m_out), 8);

        // Reset mid-fold, asserted between clock edges.
        beat(1'b1, 1, 1); beat(1'b1, 1, 1);
        @(posedge clk); #1; in_v = 1'b0;
        #2; rst_n = 1'b0;
        model_reset();
        #1;
        check_val("midreset_out", int'(m_out), 0);
        check_val("midreset_out_v", int'(m_out_v), 0);
        beat(1'b1, 5, 5); beat(1'b1, 5, 5);
        @(posedge clk); #1; in_v = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) beat(1'b1, 1, 1);
        check_val("postreset_out_before_fold", int'(m_out), 0);
        idle(4);
        check_val("postreset_out", int'(m_out), 8);

        // Wrap and signedness on the SF=1 instances.
        for (int i = 0; i < 4; i++) beat(1'b1, 7, 7);
        for (int i = 0; i < 4; i++) beat(1'b1, 15, 15);
        idle(3);
        check_val("s1_fe", int'(s_out), 8'hFE);
        check_val("u1_30", int'(u_out), 30);

        // Random streaming data.
        for (int i = 0; i < 40; i++) begin
          beat(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 10; i++) begin
          beat(1'(($urandom_range(0, 1))), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)));
        end
        idle(6);
        check_val("main_queue_drained", q_m.size(), 0);
        check_val("s1_queue_drained", q_s.size(), 0);
        check_val("u1_queue_drained", q_u.size(), 0);
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
